// File: rtl/strategy_cfg_loader.sv
// Strategy-mux configuration loader: parses SYNC/SEL/LEN/PAR*/CHK packets from the
// host byte stream, validates them and commits select + parameter word atomically.
module strategy_cfg_loader #(
  parameter int NUM_STRATEGIES = 3,
  parameter int PAR_BYTES      = 4,
  parameter int TIMEOUT_CYC    = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             strategy_sel,
  output logic [8*PAR_BYTES-1:0] par,
  output logic                   cfg_update,
  output logic                   cfg_error,
  output logic [1:0]             err_code,
  output logic [15:0]            ok_count,
  output logic [15:0]            err_count
);

  localparam int LEN_W = $clog2(PAR_BYTES + 1);
  localparam int IDX_W = (PAR_BYTES > 1) ? $clog2(PAR_BYTES) : 1;
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [2:0] {IDLE, GET_SEL, GET_LEN, GET_PAR, GET_CHK} state_t;

  state_t                      state, state_n;
  logic [7:0]                  sh_sel;
  logic [7:0]                  chk;
  logic [PAR_BYTES-1:0][7:0]   sh_par;
  logic [PAR_BYTES-1:0]        be;
  logic [LEN_W-1:0]            len;
  logic [IDX_W-1:0]            idx;
  logic [GAP_W-1:0]            gap;
  logic                        take;
  logic                        timeout;
  logic                        commit;
  logic                        abort;
  logic [1:0]                  abort_code;

  assign take    = rx_valid && rx_ready;
  // An accepted byte in the final gap cycle beats the timeout.
  assign timeout = (state != IDLE) && !take && (gap == GAP_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    commit     = 1'b0;
    abort      = 1'b0;
    abort_code = 2'd0;
    if (timeout) begin
      abort   = 1'b1;
      state_n = IDLE;
    end else if (take) begin
      case (state)
        IDLE:    if (rx_data == SYNC) state_n = GET_SEL;
        GET_SEL: state_n = GET_LEN;
        GET_LEN: begin
          if (rx_data > 8'(PAR_BYTES)) begin
            abort      = 1'b1;
            abort_code = 2'd2;
            state_n    = IDLE;
          end else if (rx_data == 8'd0) begin
            state_n = GET_CHK;
          end else begin
            state_n = GET_PAR;
          end
        end
        GET_PAR: if (LEN_W'(idx) == len - LEN_W'(1)) state_n = GET_CHK;
        GET_CHK: begin
          state_n = IDLE;
          // Checksum is judged before the select range.
          if (rx_data != chk) begin
            abort      = 1'b1;
            abort_code = 2'd1;
          end else if (sh_sel >= 8'(NUM_STRATEGIES)) begin
            abort      = 1'b1;
            abort_code = 2'd3;
          end else begin
            commit = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sh_sel <= '0;
      sh_par <= '0;
      be     <= '0;
      len    <= '0;
      idx    <= '0;
      chk    <= '0;
      gap    <= '0;
    end else begin
      gap <= (state == IDLE || take) ? '0 : gap + GAP_W'(1);
      if (commit || abort) begin
        be <= '0;
      end else if (take) begin
        case (state)
          GET_SEL: begin
            sh_sel <= rx_data;
            chk    <= rx_data;
          end
          GET_LEN: begin
            len <= rx_data[LEN_W-1:0];
            chk <= chk ^ rx_data;
            idx <= '0;
          end
          GET_PAR: begin
            sh_par[idx] <= rx_data;
            be[idx]     <= 1'b1;
            chk         <= chk ^ rx_data;
            idx         <= idx + IDX_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_ready     <= 1'b0;
      strategy_sel <= '0;
      par          <= '0;
      cfg_update   <= 1'b0;
      cfg_error    <= 1'b0;
      err_code     <= '0;
      ok_count     <= '0;
      err_count    <= '0;
    end else begin
      rx_ready   <= 1'b1;
      cfg_update <= commit;
      cfg_error  <= abort;
      if (commit) begin
        strategy_sel <= sh_sel;
        for (int k = 0; k < PAR_BYTES; k++)
          if (be[k]) par[8*k +: 8] <= sh_par[k];
        if (ok_count != 16'hFFFF) ok_count <= ok_count + 16'd1;
      end
      if (abort) begin
        err_code <= abort_code;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/strategy_cfg_loader.md
Name: strategy_cfg_loader

Overview:
- Configuration front end for the strategy mux.
- Receives a framed byte stream from the host link, decodes strategy-select and parameter packets, and validates them with a length check, an XOR checksum and a strategy-range check.
- Commits strategy_sel and the parameter word atomically, so the mux never sees a half-written configuration.
- Reports commit and error events, and keeps saturating event counters.

Parameters:
- NUM_STRATEGIES, 3: number of valid strategy indices; legal sel values are 0..NUM_STRATEGIES-1.
- PAR_BYTES, 4: width of the parameter word in bytes; PAR_W = 8*PAR_BYTES.
- TIMEOUT_CYC, 1000: maximum number of idle cycles allowed between bytes inside a packet.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready
- strategy_sel  out  8  committed strategy index, drives the mux select
- par  out  PAR_W  committed parameter word; byte k occupies bits [8k+7:8k]
- cfg_update  out  1  one-cycle pulse on commit
- cfg_error  out  1  one-cycle pulse on a packet abort
- err_code  out  2  cause of the last abort: 0 timeout, 1 checksum, 2 length, 3 select; held until the next error
- ok_count  out  16  number of committed packets, saturating
- err_count  out  16  number of aborted packets, saturating

Behaviour:
- Reset values: rx_ready=0, strategy_sel=0, par=0, cfg_update=0, cfg_error=0, err_code=0, ok_count=0, err_count=0; FSM goes to IDLE and the shadow registers are cleared.
- rx_ready is 1 in every cycle after reset deasserts; the block never back-pressures.
- Packet format: SYNC(0xA5), SEL, LEN, LEN parameter bytes (byte 0 first), CHK.
- CHK = XOR of SEL, LEN and all parameter bytes.
- FSM states: IDLE, GET_SEL, GET_LEN, GET_PAR, GET_CHK.
- IDLE: a byte of 0xA5 moves the FSM to GET_SEL. Any other byte is discarded silently; no error, no count.
- GET_SEL: store the byte in the shadow sel and seed the running checksum with it; go to GET_LEN.
- GET_LEN: LEN > PAR_BYTES aborts immediately with code 2. LEN = 0 goes to GET_CHK. Otherwise go to GET_PAR with byte index 0.
- GET_PAR:
  - Write the byte into shadow byte[idx], set byte-enable[idx], XOR it into the checksum.
  - When idx reaches LEN-1, go to GET_CHK.
- GET_CHK:
  - Checksum mismatch aborts with code 1. Checksum takes priority over the select check.
  - Otherwise, shadow sel >= NUM_STRATEGIES aborts with code 3.
  - Otherwise commit.
- Commit:
  - At the edge that accepts CHK, strategy_sel and all enabled par bytes update together.
  - Bytes not enabled keep their previous value.
  - cfg_update is high for exactly the next cycle.
  - ok_count increments.
  - FSM returns to IDLE and byte-enables clear.
- Abort:
  - cfg_error is high for one cycle and err_code is registered with it.
  - err_count increments.
  - FSM goes to IDLE; committed outputs are untouched; byte-enables clear.
- Timeout:
  - The gap counter runs in every non-IDLE state and clears on each accepted byte.
  - If the counter equals TIMEOUT_CYC-1 in a cycle with no accepted byte, abort with code 0.
  - A byte accepted in that same cycle is processed normally; the accepted byte wins.
- 0xA5 inside a packet is treated as data; there is no resynchronisation except by abort or timeout.
- Both counters saturate at 0xFFFF.
- Reset mid-packet: the packet is dropped with no cfg_error pulse, and committed outputs return to their reset values.
- cfg_update and cfg_error are never high in the same cycle.

Test Plan:
- Reset then A5 01 02 34 12 25 -> one cycle after CHK: strategy_sel=1, par=0x00001234, cfg_update one pulse, ok_count=1.
- After the first test, A5 02 01 FF FC -> strategy_sel=2, par=0x000012FF (byte 1 retained), ok_count=2.
- A5 01 02 34 12 26 -> cfg_error pulse, err_code=1, err_count=1, strategy_sel/par unchanged.
- A5 00 05 -> abort at the LEN byte with err_code=2. A5 07 00 07 -> err_code=3. Stray bytes 00 11 in IDLE -> no effect.
- A5 01 then a gap of TIMEOUT_CYC cycles -> cfg_error with err_code=0. With a gap of TIMEOUT_CYC-1 cycles followed by the remaining bytes -> normal commit.
- Assert reset in the middle of a parameter byte -> no pulses; all outputs at reset values; a following full packet commits correctly.
- Force err_count to 0xFFFF, then send a bad packet -> err_count stays 0xFFFF.
